// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

  // Frame count (power of two, minimum 2) and the derived address-split widths.
  localparam int SETS   = 16;
  localparam int IIDX_W = $clog2(SETS);
  localparam int ITAG_W = 30 - IIDX_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  // Set index of a byte address (word offset bits dropped).
  function automatic logic [IIDX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[1+IIDX_W:2];
  endfunction

  // Tag of a byte address: everything above the index.
  function automatic logic [ITAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:2+IIDX_W];
  endfunction

endpackage

// File: rtl/icache_frames.sv
// Frame store: SETS entries of {valid, tag, data}. Combinational read port,
// synchronous write port, valid bits cleared by the synchronous reset.
module icache_frames
  import icache_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic [IIDX_W-1:0] rindex_i,
  output icache_frame_t     rframe_o,
  input  logic              wen_i,
  input  logic [IIDX_W-1:0] windex_i,
  input  icache_frame_t     wframe_i
);

  logic [SETS-1:0]   valid_q;
  logic [ITAG_W-1:0] tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  // Valid bits: cleared on reset; reset wins over a same-edge refill.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (wen_i) begin
      valid_q[windex_i] <= wframe_i.valid;
    end
  end

  // Tag and data payload: written on refill only, never reset.
  always_ff @(posedge CLK) begin
    if (wen_i && nRST) begin
      tag_q[windex_i]  <= wframe_i.tag;
      data_q[windex_i] <= wframe_i.data;
    end
  end

  // Combinational read of the indexed frame.
  always_comb begin
    rframe_o.valid = valid_q[rindex_i];
    rframe_o.tag   = tag_q[rindex_i];
    rframe_o.data  = data_q[rindex_i];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, blocking, one-word-per-block instruction cache.
// Hits return in the request cycle; a miss latches its word address and
// refills from memory before any further lookup is performed.
module icache
  import icache_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  icache_state_t state_q, state_d;
  logic [31:0]   missaddr_q, missaddr_d;
  icache_frame_t rframe_s;
  icache_frame_t wframe_s;
  logic          wen_s;
  logic          hit_s;
  logic          unused_offset_s;

  // Byte offset within the word plays no role in a word-granular cache.
  assign unused_offset_s = ^imemaddr[1:0];

  icache_frames u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rindex_i (addr_index(imemaddr)),
    .rframe_o (rframe_s),
    .wen_i    (wen_s),
    .windex_i (addr_index(missaddr_q)),
    .wframe_i (wframe_s)
  );

  // Lookup compare against the frame selected by the current fetch address.
  assign hit_s = imemREN & rframe_s.valid & (rframe_s.tag == addr_tag(imemaddr));

  // Refill always writes the latched miss address, regardless of what the
  // datapath is presenting now.
  assign wframe_s = '{valid: 1'b1, tag: addr_tag(missaddr_q), data: iload};

  // State and miss-address registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      missaddr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      missaddr_q <= missaddr_d;
    end
  end

  // Next-state logic and output muxing.
  always_comb begin
    state_d    = state_q;
    missaddr_d = missaddr_q;
    ihit       = 1'b0;
    imemload   = 32'h0000_0000;
    iREN       = 1'b0;
    iaddr      = 32'h0000_0000;
    wen_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          ihit     = 1'b1;
          imemload = rframe_s.data;
        end else if (imemREN) begin
          state_d    = FETCH;
          missaddr_d = {imemaddr[31:2], 2'b00};
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = missaddr_q;
        if (!iwait) begin
          wen_s   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
